// File: rtl/mult_seq_ctrl_pkg.sv
// ============================================================================
// Module      : mult_seq_ctrl_pkg
// Description : Shared types and constants for the shift-and-add multiply
//               sequencer (state encoding, iteration count, ALU opcode).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_seq_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // One shift-and-add iteration per multiplier bit
    localparam int MUL_ITER = 32;

    // Iteration index at which the final iteration is performed
    localparam logic [4:0] CNT_LAST = 5'(MUL_ITER - 1);

    // Shared ALU opcode for addition; must track the ALU's own encoding
    localparam logic [2:0] ALU_ADD = 3'b010;

endpackage : mult_seq_ctrl_pkg

`default_nettype wire

// File: rtl/mult_seq_ctrl_if.sv
// ============================================================================
// Module      : mult_seq_ctrl_if
// Description : Bundle of the multiply request/result signals and the shared
//               ALU request/grant port. The slave side is the sequencer; the
//               master side is the core datapath (requester, ALU, arbiter).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mult_seq_ctrl_if;

    // Multiply request and result
    logic        Start;
    logic        Flush;
    logic [31:0] MulA;
    logic [31:0] MulB;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    // Shared ALU port
    logic        AluReq;
    logic        AluGnt;
    logic [31:0] AluOp1;
    logic [31:0] AluOp2;
    logic [2:0]  AluCtrl;
    logic [31:0] AluResult;

    modport slave (
        input  Start, Flush, MulA, MulB, AluGnt, AluResult,
        output Busy, Done, Hi, Lo, AluReq, AluOp1, AluOp2, AluCtrl
    );

    modport master (
        output Start, Flush, MulA, MulB, AluGnt, AluResult,
        input  Busy, Done, Hi, Lo, AluReq, AluOp1, AluOp2, AluCtrl
    );

endinterface : mult_seq_ctrl_if

`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Multi-cycle unsigned 32x32 multiply sequencer. Borrows the
//               shared ALU for every partial-product add and accumulates the
//               64-bit product in Hi/Lo, one iteration per granted cycle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    mult_seq_ctrl_if.slave  bus
);

    mul_state_t  state;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mcand;
    logic [4:0]  cnt;
    logic        busy;
    logic        done;
    logic        alu_req;

    // The ALU adds modulo 2^32; a wrapped sum is smaller than either addend,
    // which recovers the 33rd bit without a local adder.
    logic        carry;

    // Carry out of the partial-product add, recovered from the ALU result
    always_comb begin
        carry = (bus.AluResult < hi);
    end

    // Sequencer: operand load, stall-aware shift-and-add, flush and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MUL_IDLE;
            hi      <= 32'd0;
            lo      <= 32'd0;
            mcand   <= 32'd0;
            cnt     <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_req <= 1'b0;
        end else if (bus.Flush) begin
            // Cancel wins over everything; Hi/Lo keep any partial product
            state   <= MUL_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_req <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    done <= 1'b0;
                    if (bus.Start) begin
                        mcand   <= bus.MulA;
                        hi      <= 32'd0;
                        lo      <= bus.MulB;
                        cnt     <= 5'd0;
                        state   <= MUL_RUN;
                        busy    <= 1'b1;
                        alu_req <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    // Without a grant nothing moves: the iteration is retried
                    if (bus.AluGnt) begin
                        hi  <= {carry, bus.AluResult[31:1]};
                        lo  <= {bus.AluResult[0], lo[31:1]};
                        cnt <= cnt + 5'd1;
                        if (cnt == CNT_LAST) begin
                            state   <= MUL_DONE;
                            alu_req <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                MUL_DONE: begin
                    state <= MUL_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= MUL_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    alu_req <= 1'b0;
                end
            endcase
        end
    end

    // Output drive; ALU operands come straight from the accumulator
    always_comb begin
        bus.Busy    = busy;
        bus.Done    = done;
        bus.Hi      = hi;
        bus.Lo      = lo;
        bus.AluReq  = alu_req;
        bus.AluOp1  = hi;
        bus.AluOp2  = lo[0] ? mcand : 32'd0;
        bus.AluCtrl = ALU_ADD;
    end

endmodule : mult_seq_ctrl

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
// ============================================================================
// Module      : tb_mult_seq_ctrl
// Description : Directed self-checking bench for the multiply sequencer. The
//               bench models the shared ALU as a combinational adder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_ctrl;
    import mult_seq_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    mult_seq_ctrl_if bus();

    mult_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared ALU model: only the add opcode yields a sum
    assign bus.AluResult = (bus.AluCtrl == 3'b010) ? (bus.AluOp1 + bus.AluOp2) : 32'hDEAD_BEEF;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept a multiply: called #1 after a rising edge, returns #1 after E0
    task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
        bus.MulA  = a;
        bus.MulB  = b;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    // Step edges until Done; cycles = edge index of Done (-1 on timeout).
    // Optionally toggles the grant and injects one Start pulse at pulse_at.
    task automatic run_until_done(input bit toggle_gnt, input int pulse_at,
                                  output int cycles, output int hold_errs);
        logic [31:0] ph;
        logic [31:0] pl;
        cycles    = -1;
        hold_errs = 0;
        for (int i = 1; i <= 200; i++) begin
            bus.AluGnt = toggle_gnt ? (i % 2 == 0) : 1'b1;
            if (i == pulse_at) begin
                bus.Start = 1'b1;
                bus.MulA  = 32'd7;
                bus.MulB  = 32'd9;
            end else begin
                bus.Start = 1'b0;
            end
            ph = bus.Hi;
            pl = bus.Lo;
            @(posedge clk); #1;
            if (!bus.AluGnt && !bus.Done && (bus.Hi !== ph || bus.Lo !== pl))
                hold_errs++;
            if (bus.Done) begin
                cycles = i;
                break;
            end
        end
        bus.Start  = 1'b0;
        bus.AluGnt = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.Busy, bus.Done, bus.AluReq} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 000", {bus.Busy, bus.Done, bus.AluReq});
        end
        tests_run++;
        if ({bus.Hi, bus.Lo} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_hilo: got %h required 0", {bus.Hi, bus.Lo});
        end
        tests_run++;
        if (bus.AluOp1 !== 32'd0 || bus.AluOp2 !== 32'd0 || bus.AluCtrl !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_aluops: got op1=%h op2=%h ctrl=%b required 0 0 010",
                     bus.AluOp1, bus.AluOp2, bus.AluCtrl);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc;
        int he;
        start_mul(32'd3, 32'd5);
        tests_run++;
        if (bus.Busy !== 1'b1 || bus.AluReq !== 1'b1 || bus.Lo !== 32'd5 || bus.Hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL basic_load: got busy=%b req=%b hi=%h lo=%h required 1 1 0 5",
                     bus.Busy, bus.AluReq, bus.Hi, bus.Lo);
        end
        tests_run++;
        if (bus.AluOp2 !== 32'd3 || bus.AluOp1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL basic_ops: got op1=%h op2=%h required 0 3", bus.AluOp1, bus.AluOp2);
        end
        run_until_done(1'b0, 0, cyc, he);
        tests_run++;
        if (cyc !== 32) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d required 32", cyc);
        end
        tests_run++;
        if (bus.Hi !== 32'd0 || bus.Lo !== 32'd15 || bus.Busy !== 1'b1 || bus.AluReq !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got hi=%h lo=%h busy=%b req=%b required 0 f 1 0",
                     bus.Hi, bus.Lo, bus.Busy, bus.AluReq);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle_e33: got done=%b busy=%b required 0 0", bus.Done, bus.Busy);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.Hi !== 32'd0 || bus.Lo !== 32'd15 || bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_hold: got hi=%h lo=%h busy=%b required 0 f 0", bus.Hi, bus.Lo, bus.Busy);
        end
    endtask

    task automatic test_carry();
        int cyc;
        int he;
        start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_until_done(1'b0, 0, cyc, he);
        tests_run++;
        if (cyc !== 32 || bus.Hi !== 32'hFFFF_FFFE || bus.Lo !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL carry_result: got cyc=%0d hi=%h lo=%h required 32 fffffffe 00000001",
                     cyc, bus.Hi, bus.Lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stalls();
        int cyc;
        int he;
        start_mul(32'h1234_5678, 32'h9ABC_DEF0);
        run_until_done(1'b1, 0, cyc, he);
        tests_run++;
        if (cyc !== 64) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d required 64", cyc);
        end
        tests_run++;
        if (he !== 0) begin
            tests_failed++;
            $display("FAIL stall_hold: got %0d changed stalls required 0", he);
        end
        tests_run++;
        if (bus.Hi !== 32'h0B00_EA4E || bus.Lo !== 32'h242D_2080) begin
            tests_failed++;
            $display("FAIL stall_result: got hi=%h lo=%h required 0b00ea4e 242d2080", bus.Hi, bus.Lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        int cyc;
        int he;
        int pulses;
        start_mul(32'd1000, 32'd3000);
        run_until_done(1'b0, 10, cyc, he);
        pulses = (cyc > 0) ? 1 : 0;
        tests_run++;
        if (cyc !== 32 || bus.Hi !== 32'd0 || bus.Lo !== 32'h002D_C6C0) begin
            tests_failed++;
            $display("FAIL busy_start_result: got cyc=%0d hi=%h lo=%h required 32 0 002dc6c0",
                     cyc, bus.Hi, bus.Lo);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.Done) pulses++;
        end
        tests_run++;
        if (pulses !== 1 || bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_pulses: got pulses=%0d busy=%b required 1 0", pulses, bus.Busy);
        end
    endtask

    task automatic test_flush();
        int cyc;
        int he;
        int dones;
        logic [31:0] sh;
        logic [31:0] sl;
        dones = 0;
        start_mul(32'hFFFF_FFFF, 32'h0000_FFFF);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (bus.Done) dones++;
        end
        bus.Flush = 1'b1;
        sh = bus.Hi;
        sl = bus.Lo;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        if (bus.Done) dones++;
        tests_run++;
        if (bus.Busy !== 1'b0 || bus.AluReq !== 1'b0 || dones !== 0) begin
            tests_failed++;
            $display("FAIL flush_idle: got busy=%b req=%b dones=%0d required 0 0 0",
                     bus.Busy, bus.AluReq, dones);
        end
        tests_run++;
        if (bus.Hi !== sh || bus.Lo !== sl) begin
            tests_failed++;
            $display("FAIL flush_keep: got hi=%h lo=%h required %h %h", bus.Hi, bus.Lo, sh, sl);
        end
        start_mul(32'd7, 32'd6);
        run_until_done(1'b0, 0, cyc, he);
        tests_run++;
        if (cyc !== 32 || bus.Hi !== 32'd0 || bus.Lo !== 32'd42) begin
            tests_failed++;
            $display("FAIL flush_restart: got cyc=%0d hi=%h lo=%h required 32 0 2a", cyc, bus.Hi, bus.Lo);
        end
        @(posedge clk); #1;
        bus.Flush = 1'b1;
        bus.Start = 1'b1;
        bus.MulA  = 32'd9;
        bus.MulB  = 32'd9;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        bus.Start = 1'b0;
        tests_run++;
        if (bus.Busy !== 1'b0 || bus.Lo !== 32'd42 || bus.Hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL flush_beats_start: got busy=%b hi=%h lo=%h required 0 0 2a",
                     bus.Busy, bus.Hi, bus.Lo);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int he;
        start_mul(32'd11, 32'd13);
        run_until_done(1'b0, 0, cyc, he);
        @(posedge clk); #1;
        start_mul(32'h0001_0000, 32'h0001_0000);
        tests_run++;
        if (bus.Busy !== 1'b1 || bus.Lo !== 32'h0001_0000) begin
            tests_failed++;
            $display("FAIL b2b_accept: got busy=%b lo=%h required 1 00010000", bus.Busy, bus.Lo);
        end
        run_until_done(1'b0, 0, cyc, he);
        tests_run++;
        if (cyc !== 32 || bus.Hi !== 32'd1 || bus.Lo !== 32'd0) begin
            tests_failed++;
            $display("FAIL b2b_result: got cyc=%0d hi=%h lo=%h required 32 1 0", cyc, bus.Hi, bus.Lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int he;
        start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.Busy, bus.AluReq, bus.Done} !== 3'b000 || {bus.Hi, bus.Lo} !== 64'd0) begin
            tests_failed++;
            $display("FAIL rst_midrun: got busy=%b req=%b done=%b hi=%h lo=%h required all 0",
                     bus.Busy, bus.AluReq, bus.Done, bus.Hi, bus.Lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_mul(32'd2, 32'd2);
        run_until_done(1'b0, 0, cyc, he);
        tests_run++;
        if (cyc !== 32 || bus.Lo !== 32'd4 || bus.Hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_recover: got cyc=%0d hi=%h lo=%h required 32 0 4", cyc, bus.Hi, bus.Lo);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.Flush    = 1'b0;
        bus.MulA     = 32'd0;
        bus.MulB     = 32'd0;
        bus.AluGnt   = 1'b1;
        test_reset();
        test_basic();
        test_carry();
        test_stalls();
        test_start_while_busy();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mult_seq_ctrl

`default_nettype wire
